// File: rtl/prog_rom.sv
// prog_rom: instruction memory with a registered CPU fetch port and a
// chunked valid/ready load port, so a host can write a program at runtime.
// Words arrive most-significant chunk first. The assembled word is written
// on the same edge as its final chunk is accepted.
module prog_rom #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32768,
  parameter int LOAD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  load_start,
  input  logic [LOAD_WIDTH-1:0] load_byte,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  load_last,
  output logic                  loading,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  // Chunks per word; DATA_WIDTH is expected to be a multiple of LOAD_WIDTH
  // and DEPTH no larger than 2**ADDR_WIDTH.
  localparam int CHUNKS = DATA_WIDTH / LOAD_WIDTH;
  localparam int CIDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CIDX_W-1:0]   LAST_IDX  = CIDX_W'(CHUNKS - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  // Storage; never cleared so a program survives a CPU reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Control state
  state_t                state_q,      state_d;
  logic [CIDX_W-1:0]     chunk_idx_q,  chunk_idx_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                  load_done_q,  load_done_d;
  logic                  load_error_q, load_error_d;

  // Datapath state (no reset: contents are only meaningful once qualified)
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [DATA_WIDTH-1:0] data_q;

  // Derived load-path signals
  logic                  accept;
  logic                  word_complete;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  fetch_en;

  // Chunk acceptance qualifiers and the word being assembled.
  always_comb begin
    accept        = (state_q == LOAD) && load_valid;
    word_complete = (chunk_idx_q == LAST_IDX);
    overflow      = (word_count_q == DEPTH_CNT);
    // Shift the new chunk into the low end; truncation drops the oldest bits.
    shifted       = DATA_WIDTH'({asm_q, load_byte});
  end

  // Load sequencer: next state, counters, sticky flags and memory write.
  always_comb begin
    state_d      = state_q;
    chunk_idx_d  = chunk_idx_q;
    word_count_d = word_count_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;
    asm_d        = asm_q;
    mem_we       = 1'b0;
    mem_waddr    = word_count_q[ADDR_WIDTH-1:0];
    mem_wdata    = shifted;

    if (load_start) begin
      // A start pulse wins over any chunk offered on the same edge.
      state_d      = LOAD;
      chunk_idx_d  = '0;
      word_count_d = '0;
      load_done_d  = 1'b0;
      load_error_d = 1'b0;
    end else if (accept) begin
      if (overflow) begin
        // Memory full: refuse the chunk and abort.
        state_d      = IDLE;
        chunk_idx_d  = '0;
        load_error_d = 1'b1;
      end else if (word_complete) begin
        mem_we       = 1'b1;
        word_count_d = word_count_q + 1'b1;
        chunk_idx_d  = '0;
        if (load_last) begin
          state_d     = IDLE;
          load_done_d = 1'b1;
        end
      end else if (load_last) begin
        // Final chunk arrived mid-word: drop the partial word.
        state_d      = IDLE;
        chunk_idx_d  = '0;
        load_error_d = 1'b1;
      end else begin
        asm_d       = shifted;
        chunk_idx_d = chunk_idx_q + 1'b1;
      end
    end
  end

  // Fetch is served only while idle and only for addresses backed by storage.
  always_comb begin
    fetch_en = (state_q == IDLE) &&
               ((ADDR_WIDTH + 1)'(address) < DEPTH_CNT);
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      chunk_idx_q  <= '0;
      word_count_q <= '0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      chunk_idx_q  <= chunk_idx_d;
      word_count_q <= word_count_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  // Assembly register holds the leading chunks of the current word.
  always_ff @(posedge clk) begin
    asm_q <= asm_d;
  end

  // Memory write port; kept free of reset so words survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read port; outputs zero (the harmless @0 instruction) when
  // loading, in reset, or addressing beyond the populated depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (fetch_en) begin
      data_q <= mem[address];
    end else begin
      data_q <= '0;
    end
  end

  // Outputs
  assign data       = data_q;
  assign loading    = (state_q == LOAD);
  assign load_ready = (state_q == LOAD);
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_prog_rom.sv
// Scoreboard bench for prog_rom: stimulus pushes expected values tagged with
// the cycle they become visible; a monitor pops and compares on negedge.
module tb_prog_rom;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int DP = 4;
  localparam int LW = 8;

  localparam int S_DATA  = 0;
  localparam int S_LOAD  = 1;
  localparam int S_READY = 2;
  localparam int S_DONE  = 3;
  localparam int S_ERR   = 4;
  localparam int S_WC    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic          load_start;
  logic [LW-1:0] load_byte;
  logic          load_valid;
  logic          load_ready;
  logic          load_last;
  logic          loading;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   word_count;

  prog_rom #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DP), .LOAD_WIDTH(LW)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .data(data),
    .load_start(load_start), .load_byte(load_byte), .load_valid(load_valid),
    .load_ready(load_ready), .load_last(load_last), .loading(loading),
    .load_done(load_done), .load_error(load_error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_DATA:  return 32'(data);
      S_LOAD:  return 32'(loading);
      S_READY: return 32'(load_ready);
      S_DONE:  return 32'(load_done);
      S_ERR:   return 32'(load_error);
      default: return 32'(word_count);
    endcase
  endfunction

  // Monitor: compare every entry that has become due.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t        e;
      logic [31:0] a;
      e = sb.pop_front();
      a = actual(e.sel);
      n_cmp++;
      if (a !== e.exp) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): got %h, expected %h", e.name, cyc, a, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect a value on the outputs produced by the edge just passed.
  task automatic expect_now(input int sel, input logic [31:0] v, input string name);
    exp_t e;
    e.due = cyc; e.sel = sel; e.exp = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic last, input int gaps);
    for (int i = 0; i < gaps; i++) begin
      load_valid = 1'b0;
      load_byte  = 8'($urandom);
      load_last  = 1'($urandom_range(0, 1));
      tick();
    end
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input int a, input logic [15:0] v, input string name);
    address = AW'(a);
    tick();
    expect_now(S_DATA, 32'(v), name);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b2 [6];
    logic [7:0] b4 [8];
    b2 = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07};
    b4 = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};

    reset = 1'b1; address = '0; load_start = 1'b0;
    load_byte = '0; load_valid = 1'b0; load_last = 1'b0;

    // Reset state
    tick(); tick();
    expect_now(S_DATA,  0, "rst_data");
    expect_now(S_LOAD,  0, "rst_loading");
    expect_now(S_READY, 0, "rst_ready");
    expect_now(S_DONE,  0, "rst_done");
    expect_now(S_ERR,   0, "rst_error");
    expect_now(S_WC,    0, "rst_wc");
    reset = 1'b0;
    fetch(5, 16'h0000, "oor_fetch_after_reset");

    // Clean three-word load with random valid gaps
    address = '0;
    start_load();
    expect_now(S_LOAD,  1, "start_loading");
    expect_now(S_READY, 1, "start_ready");
    expect_now(S_WC,    0, "start_wc");
    for (int i = 0; i < 6; i++) begin
      send(b2[i], (i == 5), $urandom_range(0, 2));
      expect_now(S_DATA, 0, "data_zero_during_load");
      if (i == 1) expect_now(S_WC, 1, "wc_after_first_word");
    end
    expect_now(S_LOAD, 0, "load3_loading");
    expect_now(S_DONE, 1, "load3_done");
    expect_now(S_ERR,  0, "load3_error");
    expect_now(S_WC,   3, "load3_wc");
    fetch(0, 16'h1234, "fetch0_1234");
    fetch(1, 16'hABCD, "fetch1_ABCD");
    fetch(2, 16'h0007, "fetch2_0007");

    // Last on a chunk that does not complete a word
    start_load();
    expect_now(S_DONE, 0, "restart_clears_done");
    send(8'hAA, 1'b0, 0);
    send(8'hBB, 1'b0, 1);
    send(8'hCC, 1'b1, 0);
    expect_now(S_ERR,  1, "partial_error");
    expect_now(S_DONE, 0, "partial_done");
    expect_now(S_WC,   1, "partial_wc");
    expect_now(S_LOAD, 0, "partial_loading");
    fetch(0, 16'hAABB, "partial_word0");
    fetch(1, 16'hABCD, "partial_word1_unchanged");

    // Overflow with DEPTH=4
    address = AW'(1);
    start_load();
    expect_now(S_ERR, 0, "restart_clears_error");
    for (int i = 0; i < 8; i++) begin
      send(b4[i], 1'b0, $urandom_range(0, 1));
      expect_now(S_DATA, 0, "data_zero_during_fill");
    end
    expect_now(S_WC,   4, "full_wc");
    expect_now(S_LOAD, 1, "full_still_loading");
    send(8'h55, 1'b0, 0);
    expect_now(S_ERR,  1, "overflow_error");
    expect_now(S_LOAD, 0, "overflow_loading");
    expect_now(S_WC,   4, "overflow_wc");
    expect_now(S_DONE, 0, "overflow_done");
    fetch(0, 16'h1111, "fill_word0");
    fetch(1, 16'h2222, "fill_word1");
    fetch(2, 16'h3333, "fill_word2");
    fetch(3, 16'h4444, "fill_word3");
    fetch(4, 16'h0000, "oor_fetch4");
    fetch(7, 16'h0000, "oor_fetch7");

    // Restart mid-word with a chunk offered on the same edge
    start_load();
    send(8'h9A, 1'b0, 0);
    send(8'hBC, 1'b0, 0);
    expect_now(S_WC, 1, "pre_restart_wc");
    send(8'hDE, 1'b0, 0);
    load_start = 1'b1; load_valid = 1'b1; load_byte = 8'hEE; load_last = 1'b0;
    tick();
    load_start = 1'b0; load_valid = 1'b0;
    expect_now(S_WC,   0, "restart_wc");
    expect_now(S_LOAD, 1, "restart_loading");
    expect_now(S_ERR,  0, "restart_error");
    send(8'h56, 1'b0, 0);
    send(8'h78, 1'b1, 1);
    expect_now(S_DONE, 1, "restart_done");
    expect_now(S_WC,   1, "restart_final_wc");
    fetch(0, 16'h5678, "restart_word0");
    fetch(1, 16'h2222, "restart_word1_retained");

    // Reset after 1.5 words
    start_load();
    send(8'h0F, 1'b0, 0);
    send(8'hF0, 1'b0, 0);
    send(8'h11, 1'b0, 0);
    reset = 1'b1;
    tick();
    expect_now(S_LOAD,  0, "midrst_loading");
    expect_now(S_READY, 0, "midrst_ready");
    expect_now(S_ERR,   0, "midrst_error");
    expect_now(S_DONE,  0, "midrst_done");
    expect_now(S_WC,    0, "midrst_wc");
    expect_now(S_DATA,  0, "midrst_data");
    reset = 1'b0;
    fetch(0, 16'h0FF0, "midrst_word0_retained");
    fetch(1, 16'h2222, "midrst_word1_retained");
    start_load();
    send(8'h21, 1'b0, 0);
    send(8'h43, 1'b1, 0);
    expect_now(S_DONE, 1, "post_rst_load_done");
    expect_now(S_WC,   1, "post_rst_load_wc");
    fetch(0, 16'h2143, "post_rst_word0");

    // Reset clears a set done flag and masks the fetch data
    reset = 1'b1;
    tick();
    expect_now(S_DONE, 0, "rst_clears_done");
    expect_now(S_DATA, 0, "rst_masks_data");
    reset = 1'b0;
    fetch(0, 16'h2143, "final_word0");

    repeat (3) tick();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      n_fail += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
